pci_debug_comp_mux: RTL

PCI_DEBUG_COMP_MUX -- requirements
Module: pci_debug_comp_mux

---
 rtl/pci_debug_comp_mux.sv | 179 +++++++++++++++++
 1 files changed

// File: rtl/pci_debug_comp_mux.sv
// Debug read mux: forwards one tile debug burst to/from one of N_COMP components.
// Bad ids (and stalls, when PCI_DEBUG_TIMEOUT_EN is defined) are completed with DEADBEEF fill beats.
module pci_debug_comp_mux #(
    parameter int unsigned N_COMP         = 8,
    parameter int unsigned DATA_W         = 512,
    parameter int unsigned TIMEOUT_CYCLES = 1024
) (
    input  logic                       clk,
    input  logic                       rstn,
    input  logic                       req_valid,
    input  logic [7:0]                 req_comp,
    input  logic [7:0]                 req_len,
    output logic                       busy,
    output logic [N_COMP-1:0]          comp_arvalid,
    output logic [7:0]                 comp_arlen,
    output logic [N_COMP-1:0]          comp_rready,
    input  logic [N_COMP*DATA_W-1:0]   comp_rdata,
    input  logic [N_COMP-1:0]          comp_rvalid,
    input  logic [N_COMP-1:0]          comp_rlast,
    output logic [DATA_W-1:0]          rdata,
    output logic                       rvalid,
    output logic                       rlast,
    input  logic                       rready,
    output logic                       err_sticky
);

    if (N_COMP < 1 || N_COMP > 255 || TIMEOUT_CYCLES < 1) begin : g_bad_params
        $error("pci_debug_comp_mux: illegal parameter set");
    end

    localparam int unsigned FILL_WORDS = (DATA_W + 31) / 32;
    localparam logic [FILL_WORDS*32-1:0] FILL_WIDE = {FILL_WORDS{32'hDEADBEEF}};
    localparam logic [DATA_W-1:0] FILL_DATA = FILL_WIDE[DATA_W-1:0];

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        STREAM,
        FILL
    } state_e;

    state_e      state_q, state_d;
    logic [7:0]  comp_q, comp_d;
    logic [7:0]  len_q, len_d;
    logic [7:0]  beat_q, beat_d;
    logic        err_q, err_d;

`ifdef PCI_DEBUG_TIMEOUT_EN
    localparam int unsigned STALL_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [STALL_W-1:0] stall_q, stall_d;
`endif

    logic [N_COMP-1:0] sel_onehot;
    logic [DATA_W-1:0] sel_rdata;
    logic              sel_rvalid;
    logic              sel_rlast;
    logic              beat_is_last;
    logic              bad_id;

    // Select the latched component with a compare loop so the 8-bit id never indexes a narrower vector.
    always_comb begin
        sel_onehot = '0;
        sel_rdata  = '0;
        sel_rvalid = 1'b0;
        sel_rlast  = 1'b0;
        for (int unsigned i = 0; i < N_COMP; i++) begin
            if (i == {24'd0, comp_q}) begin
                sel_onehot[i] = 1'b1;
                sel_rdata     = comp_rdata[i*DATA_W +: DATA_W];
                sel_rvalid    = comp_rvalid[i];
                sel_rlast     = comp_rlast[i];
            end
        end
    end

    assign beat_is_last = (beat_q == len_q);
    assign bad_id       = ({1'b0, req_comp} >= 9'(N_COMP));
    assign comp_arlen   = len_q;
    assign err_sticky   = err_q;

    always_comb begin
        state_d = state_q;
        comp_d  = comp_q;
        len_d   = len_q;
        beat_d  = beat_q;
        err_d   = err_q;
`ifdef PCI_DEBUG_TIMEOUT_EN
        stall_d = stall_q;
`endif
        busy         = (state_q != IDLE);
        comp_arvalid = '0;
        comp_rready  = '0;
        rdata        = '0;
        rvalid       = 1'b0;
        rlast        = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (req_valid) begin
                    comp_d = req_comp;
                    len_d  = req_len;
                    beat_d = '0;
                    if (bad_id) begin
                        state_d = FILL;
                        err_d   = 1'b1;
                    end else begin
                        state_d = ISSUE;
                    end
                end
            end
            ISSUE: begin
                comp_arvalid = sel_onehot;
                state_d      = STREAM;
`ifdef PCI_DEBUG_TIMEOUT_EN
                stall_d      = '0;
`endif
            end
            STREAM: begin
                rdata       = sel_rdata;
                rvalid      = sel_rvalid;
                rlast       = sel_rlast | beat_is_last;
                comp_rready = sel_onehot & {N_COMP{rready}};
                if (sel_rvalid && rready) begin
                    beat_d = beat_q + 8'd1;
`ifdef PCI_DEBUG_TIMEOUT_EN
                    stall_d = '0;
`endif
                    if (sel_rlast || beat_is_last) begin
                        state_d = IDLE;
                    end
                end
`ifdef PCI_DEBUG_TIMEOUT_EN
                else begin
                    stall_d = stall_q + 1'b1;
                    if (stall_d == STALL_W'(TIMEOUT_CYCLES)) begin
                        state_d = FILL;
                        err_d   = 1'b1;
                    end
                end
`endif
            end
            FILL: begin
                rvalid = 1'b1;
                rdata  = FILL_DATA;
                rlast  = beat_is_last;
                if (rready) begin
                    beat_d = beat_q + 8'd1;
                    if (beat_is_last) begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= IDLE;
            comp_q  <= '0;
            len_q   <= '0;
            beat_q  <= '0;
            err_q   <= 1'b0;
`ifdef PCI_DEBUG_TIMEOUT_EN
            stall_q <= '0;
`endif
        end else begin
            state_q <= state_d;
            comp_q  <= comp_d;
            len_q   <= len_d;
            beat_q  <= beat_d;
            err_q   <= err_d;
`ifdef PCI_DEBUG_TIMEOUT_EN
            stall_q <= stall_d;
`endif
        end
    end

endmodule
